// File: rtl/rib_defines.sv
// Shared master-ID type and constants for the RIB memory arbiter.
package rib_defines;

    typedef logic [1:0] mid_t;

    localparam mid_t M_DBG = 2'd0;
    localparam mid_t M_LSU = 2'd1;
    localparam mid_t M_IF  = 2'd2;
    localparam int   NUM_M = 3;

endpackage

// File: rtl/rib_id_fifo.sv
// Master-ID FIFO: remembers which master owns each outstanding request so
// in-order responses can be routed back. Head is read before a same-cycle write.
module rib_id_fifo
    import rib_defines::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  mid_t          din,
    output mid_t          head,
    output logic [CW-1:0] cnt
);

    mid_t          mem_q [DEPTH];
    mid_t          mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= M_DBG;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/rib_mem_arbiter.sv
// Three-master single-beat arbiter onto one memory slave with in-order response routing.
// Define RIB_ARB_RR_EN to round-robin M1/M2 below the always-highest M0.
module rib_mem_arbiter
    import rib_defines::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_be,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_be,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,

    input  logic            m2_req,
    input  logic            m2_we,
    input  logic [AW-1:0]   m2_addr,
    input  logic [DW-1:0]   m2_wdata,
    input  logic [DW/8-1:0] m2_be,
    output logic            m2_gnt,
    output logic            m2_rvalid,
    output logic [DW-1:0]   m2_rdata,

    output logic            s_req,
    output logic            s_we,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_be,
    input  logic            s_gnt,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata,

    output logic            busy,
    output logic            err
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    logic [CW-1:0]    cnt;
    mid_t             head;
    mid_t             win;
    logic             any_req, can_issue, pop, gnt;
    logic [NUM_M-1:0] gnt_vec, rvalid_vec;
    logic             err_q, err_d;

    assign any_req   = m0_req | m1_req | m2_req;
    assign pop       = s_rvalid & (cnt != '0) & ~rst;
    // A response retiring this cycle frees its slot for a new push.
    assign can_issue = (cnt < MAX_CNT) | pop;
    assign s_req     = can_issue & any_req & ~rst;
    assign gnt       = s_req & s_gnt;

`ifdef RIB_ARB_RR_EN
    mid_t rr_last_q, rr_last_d;

    always_comb begin
        if (m0_req)               win = M_DBG;
        else if (m1_req & m2_req) win = (rr_last_q == M_LSU) ? M_IF : M_LSU;
        else if (m1_req)          win = M_LSU;
        else                      win = M_IF;
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt && win != M_DBG) rr_last_d = win;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_last_q <= M_IF;
        else     rr_last_q <= rr_last_d;
    end
`else
    always_comb begin
        if (m0_req)      win = M_DBG;
        else if (m1_req) win = M_LSU;
        else             win = M_IF;
    end
`endif

    always_comb begin
        case (win)
            M_DBG: begin
                s_we = m0_we; s_addr = m0_addr; s_wdata = m0_wdata; s_be = m0_be;
            end
            M_LSU: begin
                s_we = m1_we; s_addr = m1_addr; s_wdata = m1_wdata; s_be = m1_be;
            end
            default: begin
                s_we = m2_we; s_addr = m2_addr; s_wdata = m2_wdata; s_be = m2_be;
            end
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            gnt_vec[i]    = gnt & (win == mid_t'(i));
            rvalid_vec[i] = pop & (head == mid_t'(i));
        end
    end

    assign m0_gnt    = gnt_vec[M_DBG];
    assign m1_gnt    = gnt_vec[M_LSU];
    assign m2_gnt    = gnt_vec[M_IF];
    assign m0_rvalid = rvalid_vec[M_DBG];
    assign m1_rvalid = rvalid_vec[M_LSU];
    assign m2_rvalid = rvalid_vec[M_IF];
    assign m0_rdata  = m0_rvalid ? s_rdata : '0;
    assign m1_rdata  = m1_rvalid ? s_rdata : '0;
    assign m2_rdata  = m2_rvalid ? s_rdata : '0;

    rib_id_fifo #(
        .DEPTH (MAX_OUT)
    ) u_id_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (gnt),
        .pop  (pop),
        .din  (win),
        .head (head),
        .cnt  (cnt)
    );

    // An unsolicited response is a protocol violation; latch it until reset.
    assign err_d = err_q | (s_rvalid & (cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err  = err_q;
    assign busy = (cnt != '0);

endmodule
